sprite_plotter: RTL and testbench
=================================

// Module: sprite_plotter
// PURPOSE
//  Consumes the 4-bit object select from the draw sequencer and rasterises that object into the VGA adapter.
//  For each job it erases the object's previous footprint (background colour), then draws it at its current position.
//  It returns a 1-cycle done pulse, which steps the sequencer to the next object.
//  Sits between the draw sequencer and the vga_adapter (x/y/colour/plot) port.
// PARAMETERS
//  NUM_OBJ    6      object slots; select codes 0..NUM_OBJ-1 (player, enemy1..4, bullet)
//  SPR_W      4      sprite width in pixels
//  SPR_H      4      sprite height in pixels
//  SCREEN_W   160    visible width; pixels with x >= SCREEN_W are suppressed
//  SCREEN_H   120    visible height; pixels with y >= SCREEN_H are suppressed
//  BG_COLOUR  3'b000 colour used for erase
// PORTS
//  clk         in   1          system clock
//  resetn      in   1          asynchronous, active-low reset
//  enable      in   1          job start permitted while high
//  draw_sel    in   4          object select from draw sequencer
//  obj_x_bus   in   8*NUM_OBJ  current x per object, slot i at [8i+7:8i]
//  obj_y_bus   in   7*NUM_OBJ  current y per object, slot i at [7i+6:7i]
//  obj_col_bus in   3*NUM_OBJ  colour per object, slot i at [3i+2:3i]
//  obj_alive   in   NUM_OBJ    1 = object exists and is drawn
//  x           out  8          pixel x to VGA adapter
//  y           out  7          pixel y to VGA adapter
//  colour      out  3          pixel colour
//  plot        out  1          write strobe, 1 pixel per cycle
//  done        out  1          job complete, high exactly 1 cycle
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE; counters=0; all prev_valid[i]=0; x=y=colour=plot=done=0.
//  FSM states and transitions:
//   - IDLE: if enable, latch draw_sel -> LOAD; otherwise stay.
//   - LOAD: snapshot x/y/colour/alive of the latched slot.
//       - Latched sel >= NUM_OBJ -> DONE (no pixels).
//       - Otherwise, prev_valid -> ERASE.
//       - Otherwise, alive -> DRAW.
//       - Otherwise -> DONE.
//   - ERASE: scans SPR_W*SPR_H pixels at prev_x/prev_y in BG_COLOUR. When finished: alive -> DRAW, else -> DONE.
//   - DRAW: scans SPR_W*SPR_H pixels at the snapshot position in the snapshot colour -> DONE.
//   - DONE: done=1 for this cycle only -> IDLE.
//  Scan order: cx increments every cycle; at cx=SPR_W-1, cx wraps to 0 and cy increments. The phase ends after (SPR_W-1, SPR_H-1).
//  Pixel outputs are decoded from registered state and counters only (no combinational input->output path).
//   - x = base_x + cx, y = base_y + cy.
//   - Sums are computed 9/8 bits wide; plot=0 if the sum >= SCREEN_W/SCREEN_H. Clipped pixels still consume their cycle.
//  Latency, counting the IDLE cycle with enable as cycle 0:
//   - LOAD at cycle 1; first pixel at cycle 2.
//   - done at 2+N*SPR_W*SPR_H, where N = number of phases run (0, 1 or 2).
//   - Invalid sel: done at cycle 2.
//  History update in DONE for a valid slot: prev_x/prev_y <= snapshot and prev_valid <= alive. Invalid sel leaves history unchanged.
//  draw_sel and bus changes after LOAD are ignored until the next job.
//  Handshake with the sequencer: the sequencer advances on the edge ending the done cycle. The next IDLE cycle therefore sees the new select, and no job is repeated.
//  enable low while in IDLE stalls; enable is not sampled mid-job.
//  Async reset mid-job aborts immediately: plot drops, done is not issued, and all history is cleared.
// STRUCTURE
//  Shared include/package:
//   - object select codes (0..5, identical to the draw sequencer encoding)
//   - SCREEN_W/SCREEN_H
//   - colour constants
//   - the state encoding localparams
//  One sub-module: pixel_scan_counter (params W,H; inputs clear, step; outputs cx, cy, last). Instantiated once and shared by ERASE and DRAW.
//  History arrays (prev_x, prev_y, prev_valid) and the FSM live in sprite_plotter.
// TESTING
//  1 Reset, enable=1, sel=0, obj0 at (10,20), alive, col=3'b100 -> 16 plots covering x10..13, y20..23 with colour 100; done at cycle 18.
//  2 Repeat sel=0 with obj0 moved to (12,20) -> 16 BG plots at x10..13, then 16 colour plots at x12..15; done at cycle 34.
//  3 obj0 alive=0 after test 2 -> 16 BG plots only, done at cycle 18; next sel=0 job -> 0 plots, done at cycle 2.
//  4 obj1 at (158,118), alive, no history -> 4 plots (x158..159, y118..119), 12 suppressed cycles; done at cycle 18.
//  5 sel=4'd7 -> no plots, done at cycle 2, history untouched. enable=0 in IDLE for 10 cycles -> no activity.
//  6 resetn pulsed low during DRAW of test 1 -> plot=0 and done=0 immediately; rerun test 1 -> no erase phase (history cleared).

Source files
------------

// File: rtl/sprite_plotter_pkg.sv
// Shared constants for the sprite plotter: object select codes, screen size,
// colour constants and the plotter FSM state encoding.
package sprite_plotter_pkg;

  // Object slots, identical to the draw sequencer encoding.
  localparam int         NUM_OBJECTS = 6;
  localparam logic [3:0] SEL_PLAYER  = 4'd0;
  localparam logic [3:0] SEL_ENEMY1  = 4'd1;
  localparam logic [3:0] SEL_ENEMY2  = 4'd2;
  localparam logic [3:0] SEL_ENEMY3  = 4'd3;
  localparam logic [3:0] SEL_ENEMY4  = 4'd4;
  localparam logic [3:0] SEL_BULLET  = 4'd5;

  // Visible raster of the VGA adapter.
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Sprite footprint.
  localparam int SPRITE_W = 4;
  localparam int SPRITE_H = 4;

  // 3-bit RGB colours.
  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_BLUE   = 3'b001;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_CYAN   = 3'b011;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_PURPLE = 3'b101;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_WHITE  = 3'b111;
  localparam logic [2:0] COL_BG     = COL_BLACK;

  // Plotter FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ERASE = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } plot_state_t;

endpackage

// File: rtl/sprite_plotter_if.sv
// Sequencer/object-table/VGA signal bundle of the sprite plotter.
//
// Handshake: while the plotter is idle, a high enable starts one job for
// draw_sel. The plotter samples draw_sel and the object buses once (the
// cycle after the start) and then ignores them. done is high for exactly
// one cycle at the end of the job; the sequencer advances draw_sel on the
// clock edge that ends the done cycle, so the next idle cycle sees the new
// select. x/y/colour are meaningful only while plot is high; one pixel is
// written per plot cycle.
interface sprite_plotter_if #(
  parameter int NUM_OBJ = 6
) ();
  logic                 enable;
  logic [3:0]           draw_sel;
  logic [8*NUM_OBJ-1:0] obj_x_bus;
  logic [7*NUM_OBJ-1:0] obj_y_bus;
  logic [3*NUM_OBJ-1:0] obj_col_bus;
  logic [NUM_OBJ-1:0]   obj_alive;
  logic [7:0]           x;
  logic [6:0]           y;
  logic [2:0]           colour;
  logic                 plot;
  logic                 done;

  // Sequencer / object table side.
  modport master (
    output enable, draw_sel, obj_x_bus, obj_y_bus, obj_col_bus, obj_alive,
    input  x, y, colour, plot, done
  );

  // Plotter side.
  modport slave (
    input  enable, draw_sel, obj_x_bus, obj_y_bus, obj_col_bus, obj_alive,
    output x, y, colour, plot, done
  );
endinterface

// File: rtl/sprite_plotter_pixel_scan_counter.sv
// Raster scan counter over a W x H sprite footprint: cx runs fastest and
// wraps into cy. last flags the final pixel so the FSM can leave the phase
// on the same cycle; stepping past it returns both counters to zero.
module pixel_scan_counter #(
  parameter int W = 4,
  parameter int H = 4
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                clear,
  input  logic                                step,
  output logic [((W > 1) ? $clog2(W) : 1)-1:0] cx,
  output logic [((H > 1) ? $clog2(H) : 1)-1:0] cy,
  output logic                                last
);
  localparam int CXW = (W > 1) ? $clog2(W) : 1;
  localparam int CYW = (H > 1) ? $clog2(H) : 1;

  // Advance the scan position one pixel per step, row-major.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clear) begin
      cx <= '0;
      cy <= '0;
    end else if (step) begin
      if (cx == CXW'(W - 1)) begin
        cx <= '0;
        cy <= (cy == CYW'(H - 1)) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  assign last = (cx == CXW'(W - 1)) && (cy == CYW'(H - 1));
endmodule

// File: rtl/sprite_plotter.sv
// Sprite plotter: for each job from the draw sequencer, erases the object's
// previous footprint in the background colour, then draws it at its current
// position, one pixel per cycle into the VGA adapter, and pulses done.
module sprite_plotter
  import sprite_plotter_pkg::*;
#(
  parameter int         NUM_OBJ   = sprite_plotter_pkg::NUM_OBJECTS,
  parameter int         SPR_W     = sprite_plotter_pkg::SPRITE_W,
  parameter int         SPR_H     = sprite_plotter_pkg::SPRITE_H,
  parameter int         SCREEN_W  = sprite_plotter_pkg::SCREEN_W,
  parameter int         SCREEN_H  = sprite_plotter_pkg::SCREEN_H,
  parameter logic [2:0] BG_COLOUR = sprite_plotter_pkg::COL_BG
) (
  input  logic                   clk,
  input  logic                   resetn,
  sprite_plotter_if.slave        bus,
  output plot_state_t            dbg_state
);
  localparam int CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int CYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  plot_state_t state, state_nx;

  // Job latch and snapshot of the selected slot.
  logic [3:0] sel_q;
  logic [7:0] snap_x;
  logic [6:0] snap_y;
  logic [2:0] snap_col;
  logic       snap_alive;

  // Where each object was last drawn, and whether it is on screen there.
  logic [7:0]         prev_x [NUM_OBJ];
  logic [6:0]         prev_y [NUM_OBJ];
  logic [NUM_OBJ-1:0] prev_valid;

  // Slot lookup results for the latched select.
  logic       sel_ok;
  logic [7:0] slot_x;
  logic [6:0] slot_y;
  logic [2:0] slot_col;
  logic       slot_alive;
  logic [7:0] hist_x;
  logic [6:0] hist_y;
  logic       hist_valid;

  // Scan counter shared by the erase and draw phases.
  logic           scan_clear;
  logic           scan_step;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic           scan_last;

  // Pixel decode.
  logic       scanning;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  assign sel_ok    = (sel_q < 4'(NUM_OBJ));
  assign dbg_state = state;

  pixel_scan_counter #(
    .W (SPR_W),
    .H (SPR_H)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (scan_clear),
    .step   (scan_step),
    .cx     (cx),
    .cy     (cy),
    .last   (scan_last)
  );

  // Select the bus fields and history entry of the latched slot; an
  // out-of-range select matches no slot and reads as zero.
  always_comb begin
    slot_x     = '0;
    slot_y     = '0;
    slot_col   = '0;
    slot_alive = 1'b0;
    hist_x     = '0;
    hist_y     = '0;
    hist_valid = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (sel_q == 4'(i)) begin
        slot_x     = bus.obj_x_bus[8*i +: 8];
        slot_y     = bus.obj_y_bus[7*i +: 7];
        slot_col   = bus.obj_col_bus[3*i +: 3];
        slot_alive = bus.obj_alive[i];
        hist_x     = prev_x[i];
        hist_y     = prev_y[i];
        hist_valid = prev_valid[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // FSM next state and scan counter control.
  always_comb begin
    state_nx   = state;
    scan_clear = 1'b0;
    scan_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        scan_clear = 1'b1;
        if (bus.enable) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        scan_clear = 1'b1;
        if (!sel_ok)         state_nx = ST_DONE;
        else if (hist_valid) state_nx = ST_ERASE;
        else if (slot_alive) state_nx = ST_DRAW;
        else                 state_nx = ST_DONE;
      end
      ST_ERASE: begin
        scan_step = 1'b1;
        if (scan_last) state_nx = snap_alive ? ST_DRAW : ST_DONE;
      end
      ST_DRAW: begin
        scan_step = 1'b1;
        if (scan_last) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Latch the select at job start and snapshot the slot in LOAD, so later
  // bus activity cannot disturb a job in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q      <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_col   <= '0;
      snap_alive <= 1'b0;
    end else if (state == ST_IDLE && bus.enable) begin
      sel_q <= bus.draw_sel;
    end else if (state == ST_LOAD) begin
      snap_x     <= slot_x;
      snap_y     <= slot_y;
      snap_col   <= slot_col;
      snap_alive <= slot_alive;
    end
  end

  // Record where the object now sits when a valid job completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        prev_x[i] <= '0;
        prev_y[i] <= '0;
      end
      prev_valid <= '0;
    end else if (state == ST_DONE && sel_ok) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (sel_q == 4'(i)) begin
          prev_x[i]     <= snap_x;
          prev_y[i]     <= snap_y;
          prev_valid[i] <= snap_alive;
        end
      end
    end
  end

  // Decode the pixel bus from registered state only. Sums are one bit wider
  // than the coordinate so sprites hanging off the right/bottom edge are
  // suppressed rather than wrapped.
  always_comb begin
    scanning   = (state == ST_ERASE) || (state == ST_DRAW);
    base_x     = (state == ST_ERASE) ? hist_x : snap_x;
    base_y     = (state == ST_ERASE) ? hist_y : snap_y;
    sum_x      = {1'b0, base_x} + 9'(cx);
    sum_y      = {1'b0, base_y} + 8'(cy);
    bus.x      = scanning ? sum_x[7:0] : '0;
    bus.y      = scanning ? sum_y[6:0] : '0;
    bus.colour = (state == ST_ERASE) ? BG_COLOUR :
                 (state == ST_DRAW)  ? snap_col  : '0;
    bus.plot   = scanning && (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    bus.done   = (state == ST_DONE);
  end
endmodule

// File: tb/tb_sprite_plotter.sv
// Testbench for sprite_plotter: directed job table, hand-written reset and
// stall sequences, and randomized jobs checked against a footprint model.
module tb_sprite_plotter;
  import sprite_plotter_pkg::*;

  localparam int NO = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sprite_plotter_if #(.NUM_OBJ(NO)) ifc ();
  plot_state_t dbg_state;

  sprite_plotter #(.NUM_OBJ(NO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (ifc),
    .dbg_state (dbg_state)
  );

  // Object table as the bench sees it; packed onto the buses.
  logic [7:0] tb_x     [NO];
  logic [6:0] tb_y     [NO];
  logic [2:0] tb_col   [NO];
  logic       tb_alive [NO];

  always_comb begin
    ifc.obj_x_bus   = '0;
    ifc.obj_y_bus   = '0;
    ifc.obj_col_bus = '0;
    ifc.obj_alive   = '0;
    for (int i = 0; i < NO; i++) begin
      ifc.obj_x_bus[8*i +: 8]   = tb_x[i];
      ifc.obj_y_bus[7*i +: 7]   = tb_y[i];
      ifc.obj_col_bus[3*i +: 3] = tb_col[i];
      ifc.obj_alive[i]          = tb_alive[i];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];

  // Reference history: where each object is currently visible on screen.
  int m_px [NO];
  int m_py [NO];
  bit m_pv [NO];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every on-screen pixel of a SPR_W x SPR_H box, row by row.
  task automatic add_footprint(input int bx, input int by, input logic [2:0] c);
    for (int dy = 0; dy < SPRITE_H; dy++)
      for (int dx = 0; dx < SPRITE_W; dx++)
        if (bx + dx < SCREEN_W && by + dy < SCREEN_H)
          exp_q.push_back({8'(bx + dx), 7'(by + dy), c});
  endtask

  // Expected pixel stream and done cycle for a job on the current table.
  task automatic model_job(input int sel, output int exp_done);
    int phases;
    phases = 0;
    if (sel < NO) begin
      if (m_pv[sel]) begin
        add_footprint(m_px[sel], m_py[sel], COL_BG);
        phases++;
      end
      if (tb_alive[sel]) begin
        add_footprint(tb_x[sel], tb_y[sel], tb_col[sel]);
        phases++;
      end
      m_px[sel] = tb_x[sel];
      m_py[sel] = tb_y[sel];
      m_pv[sel] = tb_alive[sel];
    end
    exp_done = 2 + phases * SPRITE_W * SPRITE_H;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NO; i++) begin
      m_px[i] = 0;
      m_py[i] = 0;
      m_pv[i] = 1'b0;
    end
  endtask

  task automatic randomize_table();
    for (int i = 0; i < NO; i++) begin
      tb_x[i]     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(150, 165));
      tb_y[i]     = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(110, 125));
      tb_col[i]   = 3'($urandom_range(0, 7));
      tb_alive[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  // ---------------- driver ----------------
  // Starts a job from an idle cycle (cycle 0), collects plotted pixels and
  // returns the cycle on which done was seen (-1 if it never came). With
  // scramble set, the table and select are changed once the snapshot has
  // been taken.
  task automatic run_job(input int sel, input bit scramble, output int done_cyc);
    got_q.delete();
    done_cyc     = -1;
    ifc.draw_sel = 4'(sel);
    ifc.enable   = 1'b1;
    @(posedge clk);
    #1 ifc.enable = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (ifc.plot) got_q.push_back({ifc.x, ifc.y, ifc.colour});
      if (ifc.done) begin
        done_cyc = cyc;
        break;
      end
      if (scramble && cyc == 2) begin
        randomize_table();
        ifc.draw_sel = 4'($urandom_range(0, 15));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare_job(input string name, input int exp_done, input int got_done);
    int mism;
    mism = 0;
    check({name, " done_cycle"}, got_done, exp_done);
    check({name, " plot_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        if (mism == 0)
          $display("FAIL %s pixel[%0d]: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   name, i, got_q[i][17:10], got_q[i][9:3], got_q[i][2:0],
                   exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
        mism++;
      end
    end
    check({name, " pixel_mismatches"}, mism, 0);
    exp_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int         sel;
    int         px;
    int         py;
    logic [2:0] col;
    bit         alive;
    int         exp_plots;
    int         exp_done;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_done, mdl_done, activity;

    vecs[0] = '{0, 10, 20, COL_RED,   1'b1, 16, 18};  // fresh draw
    vecs[1] = '{0, 12, 20, COL_RED,   1'b1, 32, 34};  // erase + redraw
    vecs[2] = '{0, 12, 20, COL_RED,   1'b0, 16, 18};  // killed: erase only
    vecs[3] = '{0, 12, 20, COL_RED,   1'b0,  0,  2};  // dead, nothing on screen
    vecs[4] = '{1, 158, 118, COL_GREEN, 1'b1, 4, 18}; // corner clipping
    vecs[5] = '{7, 0, 0, COL_WHITE,   1'b1,  0,  2};  // invalid select
    vecs[6] = '{1, 158, 118, COL_GREEN, 1'b1, 8, 34}; // clipped erase + redraw

    resetn       = 1'b0;
    ifc.enable   = 1'b0;
    ifc.draw_sel = '0;
    for (int i = 0; i < NO; i++) begin
      tb_x[i] = '0; tb_y[i] = '0; tb_col[i] = '0; tb_alive[i] = 1'b0;
    end
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset plot", int'(ifc.plot), 0);
    check("reset done", int'(ifc.done), 0);
    check("reset xyc", int'({ifc.x, ifc.y, ifc.colour}), 0);
    check("reset state", int'(dbg_state), int'(ST_IDLE));
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].sel < NO) begin
        tb_x[vecs[v].sel]     = 8'(vecs[v].px);
        tb_y[vecs[v].sel]     = 7'(vecs[v].py);
        tb_col[vecs[v].sel]   = vecs[v].col;
        tb_alive[vecs[v].sel] = vecs[v].alive;
      end
      model_job(vecs[v].sel, mdl_done);
      run_job(vecs[v].sel, 1'b0, got_done);
      check($sformatf("vec%0d plots", v), got_q.size(), vecs[v].exp_plots);
      compare_job($sformatf("vec%0d", v), vecs[v].exp_done, got_done);
    end

    // enable low in IDLE: no activity for 10 cycles.
    ifc.enable   = 1'b0;
    ifc.draw_sel = 4'd0;
    activity     = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.plot || ifc.done || dbg_state != ST_IDLE) activity++;
    end
    check("stall activity", activity, 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a draw job.
    tb_x[0] = 8'd10; tb_y[0] = 7'd20; tb_col[0] = COL_RED; tb_alive[0] = 1'b1;
    ifc.draw_sel = 4'd0;
    ifc.enable   = 1'b1;
    @(posedge clk);
    #1 ifc.enable = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid-draw plot before reset", int'(ifc.plot), 1);
    resetn = 1'b0;
    #1;
    check("reset abort plot", int'(ifc.plot), 0);
    check("reset abort done", int'(ifc.done), 0);
    check("reset abort state", int'(dbg_state), int'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    model_job(0, mdl_done);
    run_job(0, 1'b0, got_done);
    check("rerun plots", got_q.size(), 16);
    compare_job("rerun", 18, got_done);

    // Randomized jobs against the model.
    for (int j = 0; j < 40; j++) begin
      int sel;
      randomize_table();
      sel = $urandom_range(0, 7);
      model_job(sel, mdl_done);
      run_job(sel, 1'b1, got_done);
      compare_job($sformatf("rand%0d sel%0d", j, sel), mdl_done, got_done);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
